// File: rtl/uart_crc_transmitter.sv
// UART CRC link transmitter: computes the CRC-16/CCITT-FALSE of one byte serially,
// then sends a 26-bit frame (start, {data,crc} LSB first, stop) on a registered line.
module uart_crc_transmitter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_start,
    input  logic [7:0]  data_in,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [15:0] crc_out
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [12:0] LAST_CNT     = 13'(CLKS_PER_BIT - 1);
    localparam logic [12:0] CALC_LOAD    = 13'd8;
    localparam logic [4:0]  LAST_BIT     = 5'd23;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        START,
        PAYLOAD,
        STOP
    } state_t;

    state_t      r_state;
    logic [12:0] r_baudCnt;
    logic [4:0]  r_bitIdx;
    logic [7:0]  r_data;
    logic [15:0] r_crc;
    logic [15:0] r_crcOut;
    logic [23:0] r_shreg;
    logic        r_txOut;
    logic        r_txBusy;
    logic        r_txDone;

    state_t      w_state;
    logic [12:0] w_baudCnt;
    logic [4:0]  w_bitIdx;
    logic [7:0]  w_data;
    logic [15:0] w_crc;
    logic [15:0] w_crcOut;
    logic [23:0] w_shreg;
    logic        w_txOut;
    logic        w_txBusy;
    logic        w_txDone;

    logic        w_bitEnd;
    logic        w_dataBit;
    logic        w_feedback;
    logic [15:0] w_crcStep;

    // In CALC the baud counter doubles as the CRC bit counter: bits 7..0 on counts 0..7.
    assign w_bitEnd   = (r_baudCnt == LAST_CNT);
    assign w_dataBit  = r_data[3'd7 - r_baudCnt[2:0]];
    assign w_feedback = r_crc[15] ^ w_dataBit;
    assign w_crcStep  = {r_crc[14:0], 1'b0} ^ (w_feedback ? CRC_POLY : 16'h0000);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_data    <= '0;
            r_crc     <= '0;
            r_crcOut  <= '0;
            r_shreg   <= '0;
            r_txOut   <= 1'b1;
            r_txBusy  <= 1'b0;
            r_txDone  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_baudCnt <= w_baudCnt;
            r_bitIdx  <= w_bitIdx;
            r_data    <= w_data;
            r_crc     <= w_crc;
            r_crcOut  <= w_crcOut;
            r_shreg   <= w_shreg;
            r_txOut   <= w_txOut;
            r_txBusy  <= w_txBusy;
            r_txDone  <= w_txDone;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_baudCnt = r_baudCnt;
        w_bitIdx  = r_bitIdx;
        w_data    = r_data;
        w_crc     = r_crc;
        w_crcOut  = r_crcOut;
        w_shreg   = r_shreg;
        w_txOut   = r_txOut;
        w_txBusy  = r_txBusy;
        w_txDone  = 1'b0;

        case (r_state)
            IDLE: begin
                w_txOut = 1'b1;
                if (tx_start) begin
                    w_data    = data_in;
                    w_crc     = CRC_INIT;
                    w_baudCnt = '0;
                    w_txBusy  = 1'b1;
                    w_state   = CALC;
                end
            end

            CALC: begin
                if (r_baudCnt == CALC_LOAD) begin
                    w_crcOut  = r_crc;
                    w_shreg   = {r_data, r_crc};
                    w_baudCnt = '0;
                    w_txOut   = 1'b0;
                    w_state   = START;
                end else begin
                    w_crc     = w_crcStep;
                    w_baudCnt = r_baudCnt + 13'd1;
                end
            end

            START: begin
                if (w_bitEnd) begin
                    w_baudCnt = '0;
                    w_bitIdx  = '0;
                    w_txOut   = r_shreg[0];
                    w_state   = PAYLOAD;
                end else begin
                    w_baudCnt = r_baudCnt + 13'd1;
                end
            end

            // The line register is loaded with the next bit on the same edge the shreg moves.
            PAYLOAD: begin
                if (w_bitEnd) begin
                    w_baudCnt = '0;
                    if (r_bitIdx == LAST_BIT) begin
                        w_txOut = 1'b1;
                        w_state = STOP;
                    end else begin
                        w_shreg  = {1'b0, r_shreg[23:1]};
                        w_txOut  = r_shreg[1];
                        w_bitIdx = r_bitIdx + 5'd1;
                    end
                end else begin
                    w_baudCnt = r_baudCnt + 13'd1;
                end
            end

            STOP: begin
                if (w_bitEnd) begin
                    w_baudCnt = '0;
                    w_txBusy  = 1'b0;
                    w_txDone  = 1'b1;
                    w_state   = IDLE;
                end else begin
                    w_baudCnt = r_baudCnt + 13'd1;
                end
            end

            default: begin
                w_state   = IDLE;
                w_baudCnt = '0;
                w_txOut   = 1'b1;
                w_txBusy  = 1'b0;
            end
        endcase
    end

    assign tx_out  = r_txOut;
    assign tx_busy = r_txBusy;
    assign tx_done = r_txDone;
    assign crc_out = r_crcOut;

endmodule

// File: tb/tb_uart_crc_transmitter.sv
// Self-checking bench for uart_crc_transmitter with a clock-per-bit of 16: a frame/CRC
// reference model plus a centre-sampling receiver model check every line bit and the timing.
module tb_uart_crc_transmitter;

   localparam int CLK_FREQ  = 16;
   localparam int BAUD_RATE = 1;
   localparam int CPB       = 16;
   localparam int PERIOD    = 10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tx_start = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        tx_out;
   logic        tx_busy;
   logic        tx_done;
   logic [15:0] crc_out;

   int vectors = 0;
   int miscompares = 0;

   uart_crc_transmitter #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .tx_start(tx_start),
      .data_in (data_in),
      .tx_out  (tx_out),
      .tx_busy (tx_busy),
      .tx_done (tx_done),
      .crc_out (crc_out)
   );

   always #(PERIOD / 2) clk = ~clk;

   // Byte-wise CRC-16/CCITT-FALSE: xor the byte into the top, then eight polynomial shifts.
   function automatic logic [15:0] refCrc(input logic [7:0] d);
      logic [15:0] c;
      c = 16'hFFFF ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic start);
      data_in  = d;
      tx_start = start;
   endtask

   // Drives one accept and follows the whole frame; with hold set, tx_start stays high
   // and data_in switches to dLater mid-frame so the next call is the back-to-back frame.
   task automatic runFrame(input logic [7:0] d, input bit repulse, input bit hold,
                           input logic [7:0] dLater, output time tStart);
      logic [15:0] expCrc;
      logic [25:0] expBits;
      logic [23:0] rxPayload;
      bit          steady;
      bit          quiet;
      expCrc    = refCrc(d);
      expBits   = {1'b1, d, expCrc, 1'b0};
      rxPayload = '0;
      tStart    = 0;
      applyStimulus(d, 1'b1);
      @(posedge clk);
      #1;
      if (!hold) tx_start = 1'b0;
      checkOutput($sformatf("busy_after_accept_%02h", d), 32'(tx_busy), 32'd1);
      quiet = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (tx_out !== 1'b1 || tx_busy !== 1'b1 || tx_done !== 1'b0) quiet = 1'b0;
      end
      checkOutput($sformatf("calc_line_high_%02h", d), 32'(quiet), 32'd1);
      for (int j = 0; j < 26; j++) begin
         steady = 1'b1;
         for (int m = 0; m < CPB; m++) begin
            @(posedge clk);
            #1;
            if (j == 0 && m == 0) tStart = $time;
            if (tx_out !== expBits[j] || tx_done !== 1'b0 || tx_busy !== 1'b1) steady = 1'b0;
            if (m == CPB / 2 && j >= 1 && j <= 24) rxPayload[j - 1] = tx_out;
            if (repulse && j == 5 && m == 0) applyStimulus(8'hFF, 1'b1);
            if (repulse && j == 6 && m == 0) tx_start = 1'b0;
            if (hold && j == 3 && m == 0) data_in = dLater;
         end
         checkOutput($sformatf("bit%0d_%02h", j, d), 32'(steady), 32'd1);
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("done_pulse_%02h", d), 32'(tx_done), 32'd1);
      checkOutput($sformatf("busy_clear_%02h", d), 32'(tx_busy), 32'd0);
      checkOutput($sformatf("line_idle_%02h", d), 32'(tx_out), 32'd1);
      checkOutput($sformatf("crc_out_%02h", d), 32'(crc_out), 32'(expCrc));
      checkOutput($sformatf("rx_data_%02h", d), 32'(rxPayload[23:16]), 32'(d));
      checkOutput($sformatf("rx_crc_%02h", d), 32'(rxPayload[15:0]), 32'(expCrc));
      if (!hold) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("done_single_%02h", d), 32'(tx_done), 32'd0);
      end
   endtask

   initial begin
      time t1;
      time t2;
      bit  quiet;
      logic [7:0] rnd;

      applyStimulus(8'h00, 1'b0);
      reset_n = 1'b0;
      #23;
      checkOutput("reset_tx_out", 32'(tx_out), 32'd1);
      checkOutput("reset_busy", 32'(tx_busy), 32'd0);
      checkOutput("reset_done", 32'(tx_done), 32'd0);
      checkOutput("reset_crc", 32'(crc_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("model_crc_00", 32'(refCrc(8'h00)), 32'h0000E1F0);
      checkOutput("model_crc_41", 32'(refCrc(8'h41)), 32'h0000B915);

      runFrame(8'h00, 1'b0, 1'b0, 8'h00, t1);
      checkOutput("crc_00_const", 32'(crc_out), 32'h0000E1F0);
      runFrame(8'h41, 1'b0, 1'b0, 8'h00, t1);
      checkOutput("crc_41_const", 32'(crc_out), 32'h0000B915);

      runFrame(8'h41, 1'b1, 1'b0, 8'h00, t1);

      runFrame(8'hA5, 1'b0, 1'b1, 8'h3C, t1);
      runFrame(8'h3C, 1'b0, 1'b0, 8'h3C, t2);
      checkOutput("start_spacing", 32'(t2 - t1), 32'(426 * PERIOD));

      for (int n = 0; n < 4; n++) begin
         rnd = 8'($urandom_range(0, 255));
         runFrame(rnd, 1'b0, 1'b0, 8'h00, t1);
      end

      rnd = 8'($urandom_range(0, 255));
      applyStimulus(rnd, 1'b1);
      @(posedge clk);
      #1;
      tx_start = 1'b0;
      repeat (9 + CPB + 5 * CPB + 3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midframe_reset_tx_out", 32'(tx_out), 32'd1);
      checkOutput("midframe_reset_busy", 32'(tx_busy), 32'd0);
      checkOutput("midframe_reset_done", 32'(tx_done), 32'd0);
      checkOutput("midframe_reset_crc", 32'(crc_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      quiet = 1'b1;
      repeat (3 * CPB) begin
         @(posedge clk);
         #1;
         if (tx_out !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) quiet = 1'b0;
      end
      checkOutput("post_reset_quiet", 32'(quiet), 32'd1);

      rnd = 8'($urandom_range(0, 255));
      runFrame(rnd, 1'b0, 1'b0, 8'h00, t1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
